txn_channel_arbiter: RTL

TXN_CHANNEL_ARBITER -- requirements
Module: txn_channel_arbiter

---
 rtl/txn_channel_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/txn_channel_arbiter.sv
// Multi-channel transaction arbiter: per-channel FIFOs, round-robin grant and a
// registered output stage. pending counts transactions in the FIFOs plus the output register.
module txn_channel_arbiter #(
   parameter int  NUM_CH     = 4,
   parameter int  DATA_WIDTH = 32,
   parameter int  FIFO_DEPTH = 4,
   localparam int ID_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int CNT_W      = $clog2(NUM_CH * FIFO_DEPTH + 2)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_CH-1:0]            s_valid,
   output logic [NUM_CH-1:0]            s_ready,
   input  logic [NUM_CH*DATA_WIDTH-1:0] s_data,
   input  logic [NUM_CH-1:0]            ch_enable,
   output logic                         m_valid,
   input  logic                         m_ready,
   output logic [DATA_WIDTH-1:0]        m_data,
   output logic [ID_W-1:0]              m_chan_id,
   output logic [CNT_W-1:0]             pending,
   output logic                         idle
);
   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int PW = AW + 1;

   logic [DATA_WIDTH-1:0] mem_q    [NUM_CH][FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] mem_d    [NUM_CH][FIFO_DEPTH];
   logic [PW-1:0]         wr_ptr_q [NUM_CH];
   logic [PW-1:0]         wr_ptr_d [NUM_CH];
   logic [PW-1:0]         rd_ptr_q [NUM_CH];
   logic [PW-1:0]         rd_ptr_d [NUM_CH];

   logic [NUM_CH-1:0]     empty;
   logic [NUM_CH-1:0]     full;
   logic [NUM_CH-1:0]     push;
   logic [NUM_CH-1:0]     pop;
   logic [NUM_CH-1:0]     eligible;

   logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]       grant_idx;
   logic [ID_W:0]         scan_idx;
   logic                  grant_found;
   logic                  load;
   logic                  out_hs;

   logic                  m_valid_q, m_valid_d;
   logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
   logic [ID_W-1:0]       m_chan_id_q, m_chan_id_d;
   logic [CNT_W-1:0]      pending_q, pending_d;
   logic [CNT_W-1:0]      push_cnt;

   // The extra pointer bit separates full (MSBs differ) from empty (pointers equal).
   always_comb begin : fifo_status
      for (int i = 0; i < NUM_CH; i++) begin
         empty[i] = (wr_ptr_q[i] == rd_ptr_q[i]);
         full[i]  = (wr_ptr_q[i][AW] != rd_ptr_q[i][AW]) &&
                    (wr_ptr_q[i][AW-1:0] == rd_ptr_q[i][AW-1:0]);
      end
   end

   // Valid/ready: a transfer happens on a rising edge where valid and ready are both high;
   // a producer holds valid and data stable until accepted.
   assign s_ready  = rst ? '0 : ~full;
   assign push     = s_valid & s_ready;
   assign eligible = ~empty & ch_enable;

   always_comb begin : rr_scan
      grant_found = 1'b0;
      grant_idx   = '0;
      scan_idx    = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         scan_idx = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
         if (scan_idx >= (ID_W+1)'(NUM_CH)) begin
            scan_idx = scan_idx - (ID_W+1)'(NUM_CH);
         end
         if (!grant_found && eligible[scan_idx[ID_W-1:0]]) begin
            grant_found = 1'b1;
            grant_idx   = scan_idx[ID_W-1:0];
         end
      end
   end

   assign load   = grant_found && (!m_valid_q || m_ready);
   assign out_hs = m_valid_q && m_ready;

   always_comb begin : next_state
      mem_d       = mem_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      pop         = '0;
      push_cnt    = '0;
      rr_ptr_d    = rr_ptr_q;
      m_valid_d   = m_valid_q;
      m_data_d    = m_data_q;
      m_chan_id_d = m_chan_id_q;
      for (int i = 0; i < NUM_CH; i++) begin
         pop[i] = load && (grant_idx == ID_W'(i));
         if (push[i]) begin
            mem_d[i][wr_ptr_q[i][AW-1:0]] = s_data[i*DATA_WIDTH +: DATA_WIDTH];
            wr_ptr_d[i] = wr_ptr_q[i] + 1'b1;
            push_cnt    = push_cnt + 1'b1;
         end
         if (pop[i]) begin
            rd_ptr_d[i] = rd_ptr_q[i] + 1'b1;
         end
      end
      if (load) begin
         m_valid_d   = 1'b1;
         m_data_d    = mem_q[grant_idx][rd_ptr_q[grant_idx][AW-1:0]];
         m_chan_id_d = grant_idx;
         rr_ptr_d    = (grant_idx == ID_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
      end else if (m_ready) begin
         m_valid_d = 1'b0;
      end
      // A load only moves a transaction from a FIFO into the output register.
      pending_d = pending_q + push_cnt - CNT_W'(out_hs);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            wr_ptr_q[i] <= '0;
            rd_ptr_q[i] <= '0;
         end
         rr_ptr_q    <= '0;
         m_valid_q   <= 1'b0;
         m_data_q    <= '0;
         m_chan_id_q <= '0;
         pending_q   <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         rr_ptr_q    <= rr_ptr_d;
         m_valid_q   <= m_valid_d;
         m_data_q    <= m_data_d;
         m_chan_id_q <= m_chan_id_d;
         pending_q   <= pending_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign m_valid   = m_valid_q;
   assign m_data    = m_data_q;
   assign m_chan_id = m_chan_id_q;
   assign pending   = pending_q;
   assign idle      = (pending_q == '0);

endmodule
